// File: rtl/comparator_search_ctrl.sv
// SAR-style binary-search initiator for a comparator_nbit peer: drives trial,
// samples smaller/equal/greater, exits early on equal and verifies the final value.
//
// state  | meaning
// IDLE   | waiting for start; trial held at 0
// TEST   | sampling comparator for bit idx of the current trial
// VERIFY | one compare of the final search value against the unknown
module comparator_search_ctrl #(
  parameter int N = 10
) (
  input  logic         clk,
  input  logic         reset_n,
  input  logic         start,
  input  logic         cmp_smaller,
  input  logic         cmp_equal,
  input  logic         cmp_greater,
  output logic [N-1:0] trial,
  output logic         busy,
  output logic         done,
  output logic [N-1:0] result,
  output logic         found,
  output logic         err
);

  localparam int IW = $clog2(N);

  typedef enum logic [1:0] {IDLE, TEST, VERIFY} state_t;

  state_t         state, state_nxt;
  logic [IW-1:0]  idx, idx_nxt;
  logic [N-1:0]   kept, kept_nxt, kept_upd;
  logic [N-1:0]   trial_nxt, result_nxt;
  logic           busy_nxt, done_nxt, found_nxt, err_nxt;
  logic           onehot;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state  <= IDLE;
      idx    <= '0;
      kept   <= '0;
      trial  <= '0;
      result <= '0;
      busy   <= 1'b0;
      done   <= 1'b0;
      found  <= 1'b0;
      err    <= 1'b0;
    end else begin
      state  <= state_nxt;
      idx    <= idx_nxt;
      kept   <= kept_nxt;
      trial  <= trial_nxt;
      result <= result_nxt;
      busy   <= busy_nxt;
      done   <= done_nxt;
      found  <= found_nxt;
      err    <= err_nxt;
    end
  end

  always_comb begin
    state_nxt  = state;
    idx_nxt    = idx;
    kept_nxt   = kept;
    trial_nxt  = trial;
    result_nxt = result;
    busy_nxt   = busy;
    done_nxt   = 1'b0;
    found_nxt  = found;
    err_nxt    = err;
    onehot     = ({cmp_smaller, cmp_equal, cmp_greater} == 3'b100) ||
                 ({cmp_smaller, cmp_equal, cmp_greater} == 3'b010) ||
                 ({cmp_smaller, cmp_equal, cmp_greater} == 3'b001);
    // trial below the unknown means the tentative bit belongs in the answer
    kept_upd   = cmp_smaller ? trial : kept;

    case (state)
      IDLE: begin
        if (start) begin
          state_nxt  = TEST;
          idx_nxt    = IW'(N - 1);
          kept_nxt   = '0;
          trial_nxt  = {1'b1, {(N-1){1'b0}}};
          result_nxt = '0;
          found_nxt  = 1'b0;
          err_nxt    = 1'b0;
          busy_nxt   = 1'b1;
        end
      end
      TEST: begin
        if (!onehot) begin
          state_nxt  = IDLE;
          result_nxt = kept;
          trial_nxt  = '0;
          err_nxt    = 1'b1;
          found_nxt  = 1'b0;
          done_nxt   = 1'b1;
          busy_nxt   = 1'b0;
        end else if (cmp_equal) begin
          state_nxt  = IDLE;
          result_nxt = trial;
          trial_nxt  = '0;
          found_nxt  = 1'b1;
          done_nxt   = 1'b1;
          busy_nxt   = 1'b0;
        end else if (idx != '0) begin
          kept_nxt   = kept_upd;
          trial_nxt  = kept_upd | ({{(N-1){1'b0}}, 1'b1} << (idx - 1'b1));
          idx_nxt    = idx - 1'b1;
        end else begin
          state_nxt  = VERIFY;
          kept_nxt   = kept_upd;
          result_nxt = kept_upd;
          trial_nxt  = kept_upd;
        end
      end
      VERIFY: begin
        state_nxt = IDLE;
        trial_nxt = '0;
        done_nxt  = 1'b1;
        busy_nxt  = 1'b0;
        if (!onehot) begin
          err_nxt   = 1'b1;
          found_nxt = 1'b0;
        end else begin
          found_nxt = cmp_equal;
        end
      end
      default: begin
        state_nxt = IDLE;
        trial_nxt = '0;
        busy_nxt  = 1'b0;
      end
    endcase
  end

endmodule

// File: tb/tb_comparator_search_ctrl.sv
// Bench for comparator_search_ctrl: behavioural comparator plus an arithmetic
// binary-search reference model, directed cases and randomized unknowns.
module tb_comparator_search_ctrl;

  localparam int N = 10;

  logic         clk = 1'b0;
  logic         reset_n = 1'b0;
  logic         start = 1'b0;
  logic         cmp_smaller, cmp_equal, cmp_greater;
  logic [N-1:0] trial, result;
  logic         busy, done, found, err;

  int           unknown = 0;
  logic         force_en = 1'b0;
  int           total = 0;
  int           bad = 0;

  always #5 clk = ~clk;

  // comparator_nbit stand-in: a = trial, b = unknown; force_en drives all-zero
  assign cmp_smaller = force_en ? 1'b0 : (int'(trial) <  unknown);
  assign cmp_equal   = force_en ? 1'b0 : (int'(trial) == unknown);
  assign cmp_greater = force_en ? 1'b0 : (int'(trial) >  unknown);

  comparator_search_ctrl #(.N(N)) dut (
    .clk         (clk),
    .reset_n     (reset_n),
    .start       (start),
    .cmp_smaller (cmp_smaller),
    .cmp_equal   (cmp_equal),
    .cmp_greater (cmp_greater),
    .trial       (trial),
    .busy        (busy),
    .done        (done),
    .result      (result),
    .found       (found),
    .err         (err)
  );

  // Reference: MSB-first search on integers; unknown becomes u2 after test chg,
  // and test number flt (N+1 = verify) sees a non-one-hot comparator.
  task automatic model(input int u, input int u2, input int chg, input int flt,
                       output int res, output bit fnd, output bit e, output int lat);
    int kept = 0;
    int cu;
    for (int t = 1; t <= N; t++) begin
      int tr = kept + (1 << (N - t));
      cu = (chg > 0 && t > chg) ? u2 : u;
      if (t == flt) begin
        res = kept; fnd = 0; e = 1; lat = t; return;
      end
      if (tr == cu) begin
        res = tr; fnd = 1; e = 0; lat = t; return;
      end
      if (tr < cu) kept = tr;
    end
    cu = (chg > 0 && N + 1 > chg) ? u2 : u;
    res = kept; lat = N + 1;
    if (flt == N + 1) begin fnd = 0; e = 1; end
    else begin fnd = (kept == cu); e = 0; end
  endtask

  // Starts a search from the current cycle (idle or done) and checks its outcome.
  // Returns while still in the done cycle so a caller can chain back-to-back.
  task automatic do_search(input string nm, input int u, input int u2, input int chg,
                           input int flt, input int busy_pulse);
    int  e_res, e_lat, cnt;
    bit  e_fnd, e_err, seen;
    model(u, u2, chg, flt, e_res, e_fnd, e_err, e_lat);
    unknown = u;
    start   = 1'b1;
    if (flt == 1) force_en = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    total++;
    if ({busy, trial} !== {1'b1, 10'd512}) begin
      bad++;
      $display("FAIL %s first_trial: busy=%0b trial=%0d, want busy=1 trial=512", nm, busy, trial);
    end
    cnt  = 0;
    seen = 1'b0;
    while (!seen && cnt < 20) begin
      if (busy_pulse > 0 && cnt == busy_pulse) start = 1'b1;
      if (flt > 1 && cnt == flt - 1) force_en = 1'b1;
      @(posedge clk); #1;
      cnt++;
      start = 1'b0;
      if (cnt == flt) force_en = 1'b0;
      if (chg > 0 && cnt == chg) unknown = u2;
      if (done) seen = 1'b1;
    end
    force_en = 1'b0;
    total++;
    if (!seen) begin
      bad++;
      $display("FAIL %s timeout: no done within %0d cycles", nm, cnt);
      return;
    end
    if (cnt != e_lat) begin
      bad++;
      $display("FAIL %s latency: got %0d, want %0d", nm, cnt, e_lat);
    end
    total++;
    if (result !== e_res[N-1:0]) begin
      bad++;
      $display("FAIL %s result: got %0d, want %0d", nm, result, e_res);
    end
    total++;
    if ({found, err} !== {e_fnd, e_err}) begin
      bad++;
      $display("FAIL %s found_err: got %0b%0b, want %0b%0b", nm, found, err, e_fnd, e_err);
    end
    total++;
    if ({busy, trial} !== {1'b0, 10'd0}) begin
      bad++;
      $display("FAIL %s done_cycle_idle: busy=%0b trial=%0d, want 0 0", nm, busy, trial);
    end
  endtask

  task automatic test_reset();
    reset_n = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    total++;
    if ({trial, result, busy, done, found, err} !== '0) begin
      bad++;
      $display("FAIL reset_state: trial=%0d result=%0d busy=%0b done=%0b found=%0b err=%0b, want all 0",
               trial, result, busy, done, found, err);
    end
    reset_n = 1'b1;
    @(posedge clk); #1;
  endtask

  task automatic test_all_zero();
    do_search("unknown0", 0, 0, 0, 0, 0);
    @(posedge clk); #1;
    total++;
    if ({done, result, found} !== {1'b0, 10'd0, 1'b1}) begin
      bad++;
      $display("FAIL unknown0_hold: done=%0b result=%0d found=%0b, want 0 0 1", done, result, found);
    end
  endtask

  task automatic test_all_ones();
    do_search("unknown1023", 1023, 0, 0, 0, 0);
    @(posedge clk); #1;
  endtask

  task automatic test_back_to_back();
    do_search("unknown512", 512, 0, 0, 0, 0);
    do_search("b2b300", 300, 0, 0, 0, 0);
    @(posedge clk); #1;
    total++;
    if (done !== 1'b0) begin
      bad++;
      $display("FAIL b2b_done_width: done=%0b one cycle after, want 0", done);
    end
  endtask

  task automatic test_fault_and_busy_start();
    do_search("fault_t3", 700, 0, 0, 3, 1);
    repeat (2) @(posedge clk);
    #1;
    total++;
    if ({busy, err, found, result} !== {1'b0, 1'b1, 1'b0, 10'd512}) begin
      bad++;
      $display("FAIL fault_hold: busy=%0b err=%0b found=%0b result=%0d, want 0 1 0 512",
               busy, err, found, result);
    end
  endtask

  task automatic test_unknown_change();
    do_search("change300to301", 300, 301, 5, 0, 0);
    @(posedge clk); #1;
  endtask

  task automatic test_reset_mid();
    unknown = 300;
    start   = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    repeat (4) @(posedge clk);
    @(negedge clk);
    reset_n = 1'b0;
    #1;
    total++;
    if ({trial, result, busy, done, found, err} !== '0) begin
      bad++;
      $display("FAIL reset_mid: trial=%0d result=%0d busy=%0b done=%0b found=%0b err=%0b, want all 0",
               trial, result, busy, done, found, err);
    end
    @(negedge clk);
    reset_n = 1'b1;
    @(posedge clk); #1;
    do_search("after_reset", 0, 0, 0, 0, 0);
    @(posedge clk); #1;
  endtask

  task automatic test_random();
    for (int k = 0; k < 25; k++) begin
      int u   = $urandom_range(0, 1023);
      int u2  = $urandom_range(0, 1023);
      int chg = ($urandom_range(0, 3) == 0) ? $urandom_range(1, 9) : 0;
      do_search("random", u, u2, chg, 0, 0);
      if ($urandom_range(0, 1) == 1) repeat ($urandom_range(1, 3)) @(posedge clk);
      #0;
    end
    @(posedge clk); #1;
  endtask

  initial begin
    test_reset();
    test_all_zero();
    test_all_ones();
    test_back_to_back();
    test_fault_and_busy_start();
    test_unknown_change();
    test_reset_mid();
    test_random();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL global_timeout: simulation did not finish");
    $fatal(1);
  end

endmodule
